// File: rtl/controller_16bit.sv
// rtl/controller_16bit.sv - step/opcode decoder for the 16-bit RISC CPU control unit
// Outputs are combinational from step, opcode and flags; only the halt flag is stored.
module controller_16bit (
  input  logic        CLK,
  input  logic        rst,
  input  logic        E,
  input  logic        WR_RAM_E,
  input  logic [2:0]  timer,
  input  logic [24:0] OP,
  input  logic        Z,
  input  logic        C,
  input  logic        N,
  input  logic        V,
  output logic        IR_E,
  output logic        PC_E,
  output logic        RD_E,
  output logic        RAM_E,
  output logic        REG_E,
  output logic        ALU_E,
  output logic        PSW_E,
  output logic        WB_E,
  output logic        OUT_E,
  output logic [4:0]  Op,
  output logic        C_flag,
  output logic        ctrl_PC,
  output logic        ctrl_WD,
  output logic        ctrl_RA,
  output logic        ctrl_A,
  output logic        ctrl_ALU,
  output logic [1:0]  ctrl_B,
  output logic [1:0]  ctrl_WA,
  output logic [1:0]  ctrl_WR,
  output logic        timer_rst_n,
  output logic        timer_E,
  output logic        done
);

  localparam logic [4:0] I_ADD = 5'd1;
  localparam logic [4:0] I_ADC = 5'd2;
  localparam logic [4:0] I_SBB = 5'd4;
  localparam logic [4:0] I_INC = 5'd11;
  localparam logic [4:0] I_DEC = 5'd12;
  localparam logic [4:0] I_CMP = 5'd13;
  localparam logic [4:0] I_MOV = 5'd14;
  localparam logic [4:0] I_LDI = 5'd15;
  localparam logic [4:0] I_LD  = 5'd16;
  localparam logic [4:0] I_ST  = 5'd17;
  localparam logic [4:0] I_JMP = 5'd18;
  localparam logic [4:0] I_JZ  = 5'd19;
  localparam logic [4:0] I_JC  = 5'd20;
  localparam logic [4:0] I_JN  = 5'd21;
  localparam logic [4:0] I_JV  = 5'd22;
  localparam logic [4:0] I_OUT = 5'd23;
  localparam logic [4:0] I_HLT = 5'd24;

  logic       halted;
  logic       run;
  logic [4:0] idx;
  logic       is_alu;

  // Lowest set bit wins; an all-zero opcode falls through to NOP (index 0).
  always_comb begin
    idx = '0;
    for (int i = 24; i >= 0; i--) begin
      if (OP[i]) idx = 5'(i);
    end
  end

  assign run    = !rst && E && !halted && !WR_RAM_E;
  assign is_alu = (idx >= I_ADD) && (idx <= I_CMP);
  assign done   = halted;

  always_ff @(posedge CLK) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (run && timer == 3'd3 && idx == I_HLT) begin
      halted <= 1'b1;
    end
  end

  always_comb begin
    IR_E        = 1'b0;
    PC_E        = 1'b0;
    RD_E        = 1'b0;
    RAM_E       = 1'b0;
    REG_E       = 1'b0;
    ALU_E       = 1'b0;
    PSW_E       = 1'b0;
    WB_E        = 1'b0;
    OUT_E       = 1'b0;
    Op          = 5'd0;
    C_flag      = 1'b0;
    ctrl_PC     = 1'b0;
    ctrl_WD     = 1'b0;
    ctrl_RA     = 1'b0;
    ctrl_A      = 1'b0;
    ctrl_ALU    = 1'b0;
    ctrl_B      = 2'b00;
    ctrl_WA     = 2'b00;
    ctrl_WR     = 2'b00;
    timer_rst_n = 1'b1;
    timer_E     = 1'b0;

    if (run) begin
      case (timer)
        3'd0: begin
          RD_E    = 1'b1;
          timer_E = 1'b1;
        end
        3'd1: begin
          IR_E    = 1'b1;
          PC_E    = 1'b1;
          timer_E = 1'b1;
        end
        3'd2: begin
          REG_E   = 1'b1;
          timer_E = 1'b1;
        end
        3'd3: begin
          timer_E = 1'b1;
          if (is_alu) begin
            ALU_E  = 1'b1;
            PSW_E  = 1'b1;
            Op     = idx;
            C_flag = (idx == I_ADC || idx == I_SBB) ? C : 1'b0;
            if (idx == I_INC || idx == I_DEC) ctrl_B = 2'b10;
          end
          // Moves go through the ALU as pass-B without touching the flags.
          case (idx)
            I_MOV: begin
              ALU_E    = 1'b1;
              ctrl_ALU = 1'b1;
            end
            I_LDI: begin
              ALU_E    = 1'b1;
              ctrl_ALU = 1'b1;
              ctrl_B   = 2'b01;
            end
            I_LD: begin
              RD_E    = 1'b1;
              ctrl_WA = 2'b01;
            end
            I_ST: begin
              RAM_E   = 1'b1;
              ctrl_WA = 2'b01;
              ctrl_RA = 1'b1;
            end
            I_JMP: begin
              PC_E    = 1'b1;
              ctrl_PC = 1'b1;
            end
            I_JZ, I_JC, I_JN, I_JV: begin
              if ((idx == I_JZ && Z) || (idx == I_JC && C) ||
                  (idx == I_JN && N) || (idx == I_JV && V)) begin
                PC_E    = 1'b1;
                ctrl_PC = 1'b1;
              end
            end
            I_OUT:   OUT_E = 1'b1;
            default: ;
          endcase
        end
        3'd4: begin
          timer_rst_n = 1'b0;
          WB_E        = (idx >= I_ADD && idx <= I_DEC) || idx == I_MOV ||
                        idx == I_LDI || idx == I_LD;
          ctrl_WD     = (idx == I_LD);
        end
        default: timer_rst_n = 1'b0;
      endcase
    end

    if (rst || halted) timer_rst_n = 1'b0;

    if (WR_RAM_E) begin
      RAM_E       = 1'b1;
      ctrl_WA     = 2'b01;
      timer_rst_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller_16bit.sv
// tb/tb_controller_16bit.sv - directed scoreboard bench for controller_16bit
module tb_controller_16bit;

  typedef struct packed {
    logic       ir, pc, rd, ram, reg_e, alu, psw, wb, out;
    logic [4:0] op;
    logic       cf, cpc, cwd, cra, ca, calu;
    logic [1:0] cb, cwa, cwr;
    logic       trn, te, done;
  } ctl_t;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        E = 1'b0;
  logic        WR_RAM_E = 1'b0;
  logic [2:0]  timer = 3'd0;
  logic [24:0] OP = '0;
  logic        Z = 1'b0, C = 1'b0, N = 1'b0, V = 1'b0;
  logic        IR_E, PC_E, RD_E, RAM_E, REG_E, ALU_E, PSW_E, WB_E, OUT_E;
  logic [4:0]  Op;
  logic        C_flag, ctrl_PC, ctrl_WD, ctrl_RA, ctrl_A, ctrl_ALU;
  logic [1:0]  ctrl_B, ctrl_WA, ctrl_WR;
  logic        timer_rst_n, timer_E, done;

  ctl_t  obs;
  ctl_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    ir_count = 0;
  logic  hlt_m = 1'b0;

  controller_16bit dut (
    .CLK(CLK), .rst(rst), .E(E), .WR_RAM_E(WR_RAM_E), .timer(timer), .OP(OP),
    .Z(Z), .C(C), .N(N), .V(V),
    .IR_E(IR_E), .PC_E(PC_E), .RD_E(RD_E), .RAM_E(RAM_E), .REG_E(REG_E),
    .ALU_E(ALU_E), .PSW_E(PSW_E), .WB_E(WB_E), .OUT_E(OUT_E), .Op(Op),
    .C_flag(C_flag), .ctrl_PC(ctrl_PC), .ctrl_WD(ctrl_WD), .ctrl_RA(ctrl_RA),
    .ctrl_A(ctrl_A), .ctrl_ALU(ctrl_ALU), .ctrl_B(ctrl_B), .ctrl_WA(ctrl_WA),
    .ctrl_WR(ctrl_WR), .timer_rst_n(timer_rst_n), .timer_E(timer_E), .done(done)
  );

  always #5 CLK = ~CLK;

  assign obs = {IR_E, PC_E, RD_E, RAM_E, REG_E, ALU_E, PSW_E, WB_E, OUT_E, Op,
                C_flag, ctrl_PC, ctrl_WD, ctrl_RA, ctrl_A, ctrl_ALU,
                ctrl_B, ctrl_WA, ctrl_WR, timer_rst_n, timer_E, done};

  function automatic logic [4:0] low_idx(input logic [24:0] o);
    logic [24:0] iso;
    logic [4:0]  r;
    iso = o & (~o + 25'd1);
    r = 5'd0;
    for (int k = 0; k < 25; k++) if (iso[k]) r = 5'(k);
    return r;
  endfunction

  function automatic ctl_t model(input logic r, e, w, h, input logic [2:0] t,
                                 input logic [4:0] i, input logic [3:0] f);
    ctl_t m;
    logic taken;
    m = '0;
    m.trn  = 1'b1;
    m.done = h;
    taken = (i == 5'd19 && f[3]) || (i == 5'd20 && f[2]) ||
            (i == 5'd21 && f[1]) || (i == 5'd22 && f[0]);
    if (!r && e && !h && !w) begin
      m.te = (t <= 3'd3);
      if (t == 3'd0) m.rd = 1'b1;
      if (t == 3'd1) begin m.ir = 1'b1; m.pc = 1'b1; end
      if (t == 3'd2) m.reg_e = 1'b1;
      if (t == 3'd3 && i inside {[5'd1:5'd13]}) begin
        m.alu = 1'b1; m.psw = 1'b1; m.op = i;
        m.cf = (i == 5'd2 || i == 5'd4) & f[2];
        m.cb = (i == 5'd11 || i == 5'd12) ? 2'b10 : 2'b00;
      end
      if (t == 3'd3 && i == 5'd14) begin m.alu = 1'b1; m.calu = 1'b1; end
      if (t == 3'd3 && i == 5'd15) begin m.alu = 1'b1; m.calu = 1'b1; m.cb = 2'b01; end
      if (t == 3'd3 && i == 5'd16) begin m.rd = 1'b1; m.cwa = 2'b01; end
      if (t == 3'd3 && i == 5'd17) begin m.ram = 1'b1; m.cwa = 2'b01; m.cra = 1'b1; end
      if (t == 3'd3 && (i == 5'd18 || taken)) begin m.pc = 1'b1; m.cpc = 1'b1; end
      if (t == 3'd3 && i == 5'd23) m.out = 1'b1;
      if (t == 3'd4) begin
        m.wb  = i inside {[5'd1:5'd12], 5'd14, 5'd15, 5'd16};
        m.cwd = (i == 5'd16);
      end
      if (t >= 3'd4) m.trn = 1'b0;
    end
    if (r || h) m.trn = 1'b0;
    if (w) begin m.ram = 1'b1; m.cwa = 2'b01; m.trn = 1'b0; end
    return m;
  endfunction

  task automatic apply(input string tag, input logic r, e, w, input logic [2:0] t,
                       input logic [24:0] o, input logic [3:0] f);
    ctl_t got, want;
    @(posedge CLK);
    #1;
    rst = r; E = e; WR_RAM_E = w; timer = t; OP = o; {Z, C, N, V} = f;
    exp_q.push_back(model(r, e, w, hlt_m, t, low_idx(o), f));
    @(negedge CLK);
    got  = obs;
    want = exp_q.pop_front();
    vectors++;
    if (got.ir) ir_count++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, want);
    end
    if (r) hlt_m = 1'b0;
    else if (e && !hlt_m && !w && t == 3'd3 && low_idx(o) == 5'd24) hlt_m = 1'b1;
  endtask

  initial begin
    @(posedge CLK);
    apply("reset0", 1, 1, 0, 3'd0, 25'd1 << 1, 4'b0000);
    apply("reset1", 1, 1, 0, 3'd2, 25'd1 << 1, 4'b0000);

    for (int t = 0; t < 5; t++) apply("add", 0, 1, 0, 3'(t), 25'd1 << 1, 4'b0000);
    for (int t = 0; t < 5; t++) apply("jz_taken", 0, 1, 0, 3'(t), 25'd1 << 19, 4'b1000);
    for (int t = 0; t < 5; t++) apply("jz_not", 0, 1, 0, 3'(t), 25'd1 << 19, 4'b0111);
    apply("adc_c", 0, 1, 0, 3'd3, 25'd1 << 2, 4'b0100);
    apply("multihot", 0, 1, 0, 3'd3, 25'b1010, 4'b0000);
    apply("op_zero3", 0, 1, 0, 3'd3, 25'd0, 4'b0000);
    apply("op_zero4", 0, 1, 0, 3'd4, 25'd0, 4'b0000);
    for (int t = 5; t < 8; t++) apply("illegal_t", 0, 1, 0, 3'(t), 25'd1 << 16, 4'b0000);

    for (int t = 0; t < 3; t++) apply("pause_pre", 0, 1, 0, 3'(t), 25'd1 << 3, 4'b0000);
    apply("pause0", 0, 0, 0, 3'd2, 25'd1 << 3, 4'b0000);
    apply("pause1", 0, 0, 0, 3'd2, 25'd1 << 3, 4'b0000);
    for (int t = 2; t < 5; t++) apply("resume", 0, 1, 0, 3'(t), 25'd1 << 3, 4'b0000);

    apply("loader0", 0, 1, 1, 3'd0, 25'd1 << 1, 4'b0000);
    apply("loader1", 0, 1, 1, 3'd1, 25'd1 << 1, 4'b0000);

    ir_count = 0;
    for (int k = 0; k < 25; k++)
      for (int t = 0; t < 5; t++)
        apply("walk", 0, 1, 0, 3'(t), 25'd1 << k, 4'b1010);
    vectors++;
    assert (ir_count == 25) else begin
      miscompares++;
      $error("FAIL ir_pulses got=%0d exp=25", ir_count);
    end
    apply("halted0", 0, 1, 0, 3'd0, 25'd1 << 1, 4'b0000);
    apply("halted1", 0, 1, 0, 3'd1, 25'd1 << 1, 4'b0000);
    apply("halt_rst", 1, 1, 0, 3'd0, 25'd1 << 1, 4'b0000);
    apply("post_rst", 0, 1, 0, 3'd0, 25'd1 << 1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
